// File: rtl/census_match.sv
// Census-code matcher custom instruction: keeps a window of right-image codes
// and returns the winner-take-all disparity and Hamming cost for a left code.
module census_match #(
  parameter int CODE_W   = 32,
  parameter int MAX_DISP = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [3:0]  n,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  localparam int PC_W = $clog2(CODE_W + 1);
  localparam int IW   = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } state_t;

  state_t state, state_d;

  logic [CODE_W-1:0] win [MAX_DISP];
  logic [CODE_W-1:0] lcode, lcode_d;
  logic [CODE_W-1:0] diff;
  logic [CNT_W-1:0]  valid_cnt, cnt_d;
  logic [CNT_W-1:0]  idx, idx_d;
  logic [CNT_W-1:0]  best_d, best_d_d;
  logic [15:0]       best_cost, best_cost_d;
  logic [31:0]       result_d;
  logic [PC_W-1:0]   cost;
  logic [15:0]       cost_x;
  logic              better;
  logic              push;

  always_comb begin
    diff = lcode ^ win[idx[IW-1:0]];
    cost = '0;
    for (int i = 0; i < CODE_W; i++) begin
      cost = cost + PC_W'(diff[i]);
    end
    cost_x = 16'(cost);
    // Strict compare keeps the lowest disparity on ties
    better = cost_x < best_cost;
  end

  always_comb begin
    state_d     = state;
    lcode_d     = lcode;
    cnt_d       = valid_cnt;
    idx_d       = idx;
    best_d_d    = best_d;
    best_cost_d = best_cost;
    result_d    = result;
    push        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (n == 4'd2 && valid_cnt != '0) begin
            state_d     = SCAN;
            lcode_d     = dataa[CODE_W-1:0];
            idx_d       = '0;
            best_cost_d = '1;
            best_d_d    = '0;
          end else begin
            state_d = FIN;
            unique case (n)
              4'd0: begin
                cnt_d    = '0;
                result_d = '0;
              end
              4'd1: begin
                push = 1'b1;
                if (valid_cnt != CNT_W'(MAX_DISP)) begin
                  cnt_d = valid_cnt + CNT_W'(1);
                end
                result_d = {{(32-CNT_W){1'b0}}, cnt_d};
              end
              4'd2:    result_d = '1;
              4'd3:    result_d = {{(32-CNT_W){1'b0}}, valid_cnt};
              default: result_d = '0;
            endcase
          end
        end
      end
      SCAN: begin
        if (better) begin
          best_cost_d = cost_x;
          best_d_d    = idx;
        end
        if (idx == valid_cnt - CNT_W'(1)) begin
          state_d  = FIN;
          result_d = {{(16-CNT_W){1'b0}}, best_d_d, best_cost_d};
        end else begin
          idx_d = idx + CNT_W'(1);
        end
      end
      FIN: begin
        done    = clk_en;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lcode     <= '0;
      valid_cnt <= '0;
      idx       <= '0;
      best_d    <= '0;
      best_cost <= '0;
      result    <= '0;
      for (int k = 0; k < MAX_DISP; k++) begin
        win[k] <= '0;
      end
    end else if (clk_en) begin
      state     <= state_d;
      lcode     <= lcode_d;
      valid_cnt <= cnt_d;
      idx       <= idx_d;
      best_d    <= best_d_d;
      best_cost <= best_cost_d;
      result    <= result_d;
      if (push) begin
        for (int k = MAX_DISP - 1; k > 0; k--) begin
          win[k] <= win[k-1];
        end
        win[0] <= dataa[CODE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_census_match.sv
// Scoreboard bench for census_match: queue-based reference window,
// randomized opcodes and clk_en patterns, monitor checks result and latency.
module tb_census_match;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [3:0]  n;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  census_match dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mwin[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int unsigned en_cnt = 0;
  logic [31:0] last_res = '0;
  logic [31:0] pushed[$];

  always @(posedge clk) begin
    if (clk_en && !reset) en_cnt <= en_cnt + 1;
  end

  // Reference: plain list of right codes, newest first
  function automatic void model_op(input logic [3:0] op, input logic [31:0] d,
                                   output logic [31:0] res, output int lat);
    int best, bd, c;
    lat = 1;
    res = '0;
    case (op)
      4'd0: mwin.delete();
      4'd1: begin
        mwin.push_front(d);
        if (mwin.size() > 16) void'(mwin.pop_back());
        res = mwin.size();
      end
      4'd2: begin
        if (mwin.size() == 0) begin
          res = 32'hFFFF_FFFF;
        end else begin
          best = 1000;
          bd = 0;
          foreach (mwin[i]) begin
            c = $countones(d ^ mwin[i]);
            if (c < best) begin
              best = c;
              bd = i;
            end
          end
          res = {bd[15:0], best[15:0]};
          lat = mwin.size() + 1;
        end
      end
      4'd3: res = mwin.size();
      default: res = '0;
    endcase
  endfunction

  // mode 0: clk_en=1; 1: clk_en toggles every 4 cycles + spurious starts; 2: random clk_en
  task automatic issue(input logic [3:0] op, input logic [31:0] d, input int mode);
    logic [31:0] r;
    int lat, k;
    int unsigned s;
    exp_t e;
    model_op(op, d, r, lat);
    start = 1'b1;
    n = op;
    dataa = d;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    s = en_cnt;
    start = 1'b0;
    e.res = r;
    e.at = s + lat - 1;
    exp_q.push_back(e);
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      if (mode == 1) clk_en = ((k >> 2) & 1) == 0;
      else if (mode == 2) clk_en = 1'($urandom % 2);
      else clk_en = 1'b1;
      if (mode == 1 && int'(en_cnt - s) <= lat - 1) begin
        start = 1'b1;
        n = 4'($urandom % 4);
        dataa = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d got no done, required done within budget", op);
      exp_q.delete();
    end
    start = 1'b0;
    clk_en = 1'b1;
    n = 4'd0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_res = '0;
      end else if (done) begin
        done_seen++;
        checks++;
        if (!clk_en) begin
          errors++;
          $display("FAIL done_gate done=1 with clk_en=0, required 0");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done result=%h, required no done", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res) begin
            errors++;
            $display("FAIL result got %h required %h", result, e.res);
          end
          checks++;
          if (en_cnt != e.at) begin
            errors++;
            $display("FAIL latency done at en_cycle %0d required %0d", en_cnt, e.at);
          end
        end
        last_res = result;
      end else if (exp_q.size() == 0) begin
        checks++;
        if (result !== last_res) begin
          errors++;
          $display("FAIL hold result=%h required %h", result, last_res);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ds, r;
    logic [31:0] d;
    logic [3:0] op;
    reset = 1'b1;
    start = 1'b0;
    n = '0;
    dataa = '0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state result=%h done=%b required 0/0", result, done);
    end
    reset = 1'b0;

    // reset mid-MATCH aborts without done
    issue(4'd1, 32'h11, 0);
    issue(4'd1, 32'h22, 0);
    issue(4'd1, 32'h33, 0);
    start = 1'b1;
    n = 4'd2;
    dataa = 32'h5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    ds = done_seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mwin.delete();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_seen != ds) begin
      errors++;
      $display("FAIL reset_abort done pulses=%0d required 0", done_seen - ds);
    end
    issue(4'd3, 32'h0, 0);

    // basic match, then tie
    foreach (pushed[i]) pushed.delete(i);
    issue(4'd1, 32'h0, 0);
    issue(4'd1, 32'h1, 0);
    issue(4'd1, 32'h3, 0);
    issue(4'd1, 32'h7, 0);
    issue(4'd2, 32'h3, 0);
    issue(4'd0, 32'h0, 0);
    issue(4'd1, 32'h1, 0);
    issue(4'd1, 32'h2, 0);
    issue(4'd2, 32'h3, 0);

    // overflow: 20 pushes
    pushed.delete();
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      pushed.push_back(d);
      issue(4'd1, d, 0);
    end
    issue(4'd3, 32'h0, 0);
    issue(4'd2, pushed[16], 0);
    issue(4'd2, pushed[4], 0);
    issue(4'd2, pushed[0], 0);

    // empty window and NOP opcode
    issue(4'd0, 32'h0, 0);
    issue(4'd2, 32'h6, 0);
    issue(4'd8, 32'h0, 0);

    // clk_en toggling with spurious starts
    issue(4'd1, 32'h0, 0);
    issue(4'd1, 32'h1, 0);
    issue(4'd1, 32'h3, 0);
    issue(4'd1, 32'h7, 0);
    issue(4'd2, 32'h3, 1);
    issue(4'd3, 32'h0, 1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom % 10;
      if (r < 4) op = 4'd1;
      else if (r < 7) op = 4'd2;
      else if (r == 7) op = 4'd3;
      else if (r == 8) op = 4'd0;
      else op = 4'($urandom_range(4, 15));
      d = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 15));
      issue(op, d, int'($urandom % 3));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
